// File: rtl/scr2_pkg.sv
// Shared definitions for the scr2 machine-mode CSR file: CSR addresses,
// access-op encoding, mstatus/mie/mip bit positions and the RW/RS/RC helper.
package scr2_pkg;

    localparam logic [11:0] CSR_MSTATUS    = 12'h300;
    localparam logic [11:0] CSR_MISA       = 12'h301;
    localparam logic [11:0] CSR_MIE        = 12'h304;
    localparam logic [11:0] CSR_MTVEC      = 12'h305;
    localparam logic [11:0] CSR_MCOUNTEREN = 12'h306;
    localparam logic [11:0] CSR_MEPC       = 12'h341;
    localparam logic [11:0] CSR_MCAUSE     = 12'h342;
    localparam logic [11:0] CSR_MIP        = 12'h344;
    localparam logic [11:0] CSR_MCYCLE     = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET   = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH    = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH  = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID  = 12'hF11;
    localparam logic [11:0] CSR_MARCHID    = 12'hF12;
    localparam logic [11:0] CSR_MIMPID     = 12'hF13;
    localparam logic [11:0] CSR_MHARTID    = 12'hF14;

    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int MEIE_BIT       = 11;
    localparam int MEIP_BIT       = 11;

    function automatic logic [31:0] csr_apply(csr_op_e op, logic [31:0] old_val,
                                              logic [31:0] wdata);
        logic [31:0] result;
        result = old_val;
        case (op)
            CSR_OP_RW: result = wdata;
            CSR_OP_RS: result = old_val | wdata;
            CSR_OP_RC: result = old_val & ~wdata;
            default:   result = old_val;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/scr2_if.sv
// CSR access bus between the core (master) and the scr2 CSR file (slave).
interface scr2_if;
    logic [11:0] csr_addr_i;
    logic [1:0]  csr_op_i;
    logic [31:0] csr_wdata_i;
    logic [31:0] csr_rdata_o;
    logic        csr_illegal_o;

    modport master (
        output csr_addr_i, csr_op_i, csr_wdata_i,
        input  csr_rdata_o, csr_illegal_o
    );

    modport slave (
        input  csr_addr_i, csr_op_i, csr_wdata_i,
        output csr_rdata_o, csr_illegal_o
    );
endinterface

// File: rtl/scr2_counter64.sv
// 64-bit wrapping counter whose halves can be overwritten independently;
// a write in a cycle takes precedence over that cycle's increment.
module scr2_counter64 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] value_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            value_o <= 64'd0;
        end else if (wr_lo_i || wr_hi_i) begin
            if (wr_lo_i) value_o[31:0]  <= wdata_i;
            if (wr_hi_i) value_o[63:32] <= wdata_i;
        end else if (inc_i) begin
            value_o <= value_o + 64'd1;
        end
    end

endmodule

// File: rtl/scr2.sv
// Machine-mode CSR file for the RV32 core: RW/RS/RC access, trap/mret, irq.
// Define SCR2_COUNTERS_EN to build the mcycle/minstret counter hardware.
module scr2
    import scr2_pkg::*;
#(
    parameter logic [31:0] HART_ID   = 32'd0,
    parameter logic [31:0] VENDOR_ID = 32'd0,
    parameter logic [31:0] MISA_VAL  = 32'h4000_0100,
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    scr2_if.slave       csr,
    input  logic        trap_i,
    input  logic [31:0] trap_cause_i,
    input  logic [31:0] trap_pc_i,
    input  logic        mret_i,
    input  logic        instret_i,
    input  logic        irq_ext_i,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o,
    output logic        irq_o
);

    logic        mstatus_mie_q;
    logic        mstatus_mpie_q;
    logic        mie_meie_q;
    logic [29:0] mtvec_q;
    logic [31:0] mcounteren_q;
    logic [29:0] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] rdata_q;
    logic        illegal_q;

    csr_op_e     op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] old_val;
    logic [31:0] new_val;
    logic        implemented;
    logic        access;
    logic        write_req;
    logic        illegal;
    logic        do_write;

`ifdef SCR2_COUNTERS_EN
    logic [63:0] mcycle_val;
    logic [63:0] minstret_val;

    scr2_counter64 u_mcycle (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (1'b1),
        .wr_lo_i (do_write && addr == CSR_MCYCLE),
        .wr_hi_i (do_write && addr == CSR_MCYCLEH),
        .wdata_i (new_val),
        .value_o (mcycle_val)
    );

    scr2_counter64 u_minstret (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (instret_i),
        .wr_lo_i (do_write && addr == CSR_MINSTRET),
        .wr_hi_i (do_write && addr == CSR_MINSTRETH),
        .wdata_i (new_val),
        .value_o (minstret_val)
    );
`else
    logic unused_instret;
    assign unused_instret = instret_i;
`endif

    assign op    = csr_op_e'(csr.csr_op_i);
    assign addr  = csr.csr_addr_i;
    assign wdata = csr.csr_wdata_i;

    // Old value of the addressed CSR; unknown addresses clear `implemented`.
    always_comb begin
        old_val     = '0;
        implemented = 1'b1;
        case (addr)
            CSR_MISA:      old_val = MISA_VAL;
            CSR_MVENDORID: old_val = VENDOR_ID;
            CSR_MARCHID:   old_val = '0;
            CSR_MIMPID:    old_val = '0;
            CSR_MHARTID:   old_val = HART_ID;
            CSR_MSTATUS: begin
                old_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
                old_val[MSTATUS_MIE]                   = mstatus_mie_q;
                old_val[MSTATUS_MPIE]                  = mstatus_mpie_q;
            end
            CSR_MIE:        old_val[MEIE_BIT] = mie_meie_q;
            CSR_MTVEC:      old_val = {mtvec_q, 2'b00};
            CSR_MCOUNTEREN: old_val = mcounteren_q;
            CSR_MEPC:       old_val = {mepc_q, 2'b00};
            CSR_MCAUSE:     old_val = mcause_q;
            CSR_MIP:        old_val[MEIP_BIT] = irq_ext_i;
`ifdef SCR2_COUNTERS_EN
            CSR_MCYCLE:     old_val = mcycle_val[31:0];
            CSR_MCYCLEH:    old_val = mcycle_val[63:32];
            CSR_MINSTRET:   old_val = minstret_val[31:0];
            CSR_MINSTRETH:  old_val = minstret_val[63:32];
`else
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: old_val = '0;
`endif
            default:        implemented = 1'b0;
        endcase
    end

    // RS/RC with an all-zero mask is a pure read and may target read-only space.
    assign access    = op != CSR_OP_NONE;
    assign write_req = (op == CSR_OP_RW) || (access && wdata != 32'd0);
    assign illegal   = access && (!implemented || (write_req && addr[11:10] == 2'b11));
    assign do_write  = access && write_req && !illegal && !trap_i && !mret_i;
    assign new_val   = csr_apply(op, old_val, wdata);

    // Trap and mret pre-empt a same-cycle CSR access, which returns 0 and is replayed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_meie_q     <= 1'b0;
            mtvec_q        <= MTVEC_RST[31:2];
            mcounteren_q   <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            rdata_q        <= '0;
            illegal_q      <= 1'b0;
        end else begin
            rdata_q   <= '0;
            illegal_q <= 1'b0;
            if (trap_i) begin
                mepc_q         <= trap_pc_i[31:2];
                mcause_q       <= trap_cause_i;
                mstatus_mpie_q <= mstatus_mie_q;
                mstatus_mie_q  <= 1'b0;
            end else if (mret_i) begin
                mstatus_mie_q  <= mstatus_mpie_q;
                mstatus_mpie_q <= 1'b1;
            end else if (access) begin
                if (illegal) begin
                    illegal_q <= 1'b1;
                end else begin
                    rdata_q <= old_val;
                end
                if (do_write) begin
                    case (addr)
                        CSR_MSTATUS: begin
                            mstatus_mie_q  <= new_val[MSTATUS_MIE];
                            mstatus_mpie_q <= new_val[MSTATUS_MPIE];
                        end
                        CSR_MIE:        mie_meie_q   <= new_val[MEIE_BIT];
                        CSR_MTVEC:      mtvec_q      <= new_val[31:2];
                        CSR_MCOUNTEREN: mcounteren_q <= new_val;
                        CSR_MEPC:       mepc_q       <= new_val[31:2];
                        CSR_MCAUSE:     mcause_q     <= new_val;
                        default: ;
                    endcase
                end
            end
        end
    end

    assign csr.csr_rdata_o   = rdata_q;
    assign csr.csr_illegal_o = illegal_q;
    assign mtvec_o           = {mtvec_q, 2'b00};
    assign mepc_o            = {mepc_q, 2'b00};
    assign irq_o             = mstatus_mie_q & mie_meie_q & irq_ext_i;

endmodule

// File: tb/tb_scr2.sv
// Self-checking bench for scr2: directed vector table, corner sequences and
// randomized traffic checked against a mask-based behavioural CSR model.
module tb_scr2;

    localparam logic [31:0] HART_ID   = 32'd5;
    localparam logic [31:0] VENDOR_ID = 32'h0000_0ABC;
    localparam logic [31:0] MISA_VAL  = 32'h4000_0100;
    localparam logic [31:0] MTVEC_RST = 32'h0000_1000;
`ifdef SCR2_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        trap, mret, instret, irq_ext;
    logic [31:0] trap_cause, trap_pc;
    logic [31:0] mtvec_o, mepc_o;
    logic        irq_o;

    int tests_run = 0;
    int tests_failed = 0;

    scr2_if csr_bus ();

    scr2 #(
        .HART_ID   (HART_ID),
        .VENDOR_ID (VENDOR_ID),
        .MISA_VAL  (MISA_VAL),
        .MTVEC_RST (MTVEC_RST)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .csr          (csr_bus),
        .trap_i       (trap),
        .trap_cause_i (trap_cause),
        .trap_pc_i    (trap_pc),
        .mret_i       (mret),
        .instret_i    (instret),
        .irq_ext_i    (irq_ext),
        .mtvec_o      (mtvec_o),
        .mepc_o       (mepc_o),
        .irq_o        (irq_o)
    );

    always #5 clk = ~clk;

    // Reference model: a table of stored CSR words plus per-CSR writable masks.
    logic [31:0] m_csr [int];
    logic [63:0] m_cycle, m_instret;
    logic [31:0] exp_rdata;
    logic        exp_ill;

    function automatic logic [31:0] wmask(int a);
        case (a)
            'h300:        return 32'h0000_0088;
            'h304:        return 32'h0000_0800;
            'h305, 'h341: return 32'hFFFF_FFFC;
            'h306, 'h342: return 32'hFFFF_FFFF;
            default:      return 32'h0;
        endcase
    endfunction

    function automatic bit is_impl(int a);
        return a inside {'h300, 'h301, 'h304, 'h305, 'h306, 'h341, 'h342, 'h344,
                         'hB00, 'hB02, 'hB80, 'hB82, 'hF11, 'hF12, 'hF13, 'hF14};
    endfunction

    function automatic logic [31:0] model_read(int a, logic ext);
        case (a)
            'h301:        return MISA_VAL;
            'hF11:        return VENDOR_ID;
            'hF14:        return HART_ID;
            'hF12, 'hF13: return 32'h0;
            'h300:        return m_csr[a] | 32'h0000_1800;
            'h344:        return ext ? 32'h0000_0800 : 32'h0;
            'hB00:        return CNT_EN ? m_cycle[31:0] : 32'h0;
            'hB80:        return CNT_EN ? m_cycle[63:32] : 32'h0;
            'hB02:        return CNT_EN ? m_instret[31:0] : 32'h0;
            'hB82:        return CNT_EN ? m_instret[63:32] : 32'h0;
            default:      return m_csr.exists(a) ? m_csr[a] : 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        foreach (m_csr[k]) m_csr[k] = 32'h0;
        m_csr['h300] = 0; m_csr['h304] = 0; m_csr['h306] = 0;
        m_csr['h341] = 0; m_csr['h342] = 0;
        m_csr['h305] = MTVEC_RST;
        m_cycle = 64'd0;
        m_instret = 64'd0;
    endtask

    task automatic model_step(input logic r, input logic [11:0] addr, input logic [1:0] op,
                              input logic [31:0] wd, input logic tr, input logic [31:0] cause,
                              input logic [31:0] pc, input logic mr, input logic ir,
                              input logic ext);
        int a;
        bit cyc_wr, ins_wr, writes;
        logic [31:0] old, nv, ms;
        a = int'(addr);
        cyc_wr = 0; ins_wr = 0;
        exp_rdata = 32'h0; exp_ill = 1'b0;
        if (r) begin
            model_reset();
            return;
        end
        ms = m_csr['h300];
        if (tr) begin
            m_csr['h341] = pc & 32'hFFFF_FFFC;
            m_csr['h342] = cause;
            m_csr['h300] = (ms[3] ? 32'h80 : 32'h0);
        end else if (mr) begin
            m_csr['h300] = 32'h80 | (ms[7] ? 32'h8 : 32'h0);
        end else if (op != 2'b00) begin
            writes = (op == 2'b01) || (wd != 0);
            if (!is_impl(a) || (writes && addr[11:10] == 2'b11)) begin
                exp_ill = 1'b1;
            end else begin
                old = model_read(a, ext);
                exp_rdata = old;
                if (writes) begin
                    nv = (op == 2'b01) ? wd : (op == 2'b10) ? (old | wd) : (old & ~wd);
                    if (CNT_EN && a == 'hB00) begin m_cycle[31:0] = nv; cyc_wr = 1; end
                    else if (CNT_EN && a == 'hB80) begin m_cycle[63:32] = nv; cyc_wr = 1; end
                    else if (CNT_EN && a == 'hB02) begin m_instret[31:0] = nv; ins_wr = 1; end
                    else if (CNT_EN && a == 'hB82) begin m_instret[63:32] = nv; ins_wr = 1; end
                    else if (wmask(a) != 0) m_csr[a] = (m_csr[a] & ~wmask(a)) | (nv & wmask(a));
                end
            end
        end
        if (!cyc_wr) m_cycle = m_cycle + 64'd1;
        if (!ins_wr && ir) m_instret = m_instret + 64'd1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, step the model, and compare after the edge.
    task automatic applyStimulus(input logic r, input logic [11:0] addr, input logic [1:0] op,
                                 input logic [31:0] wd, input logic tr, input logic [31:0] cause,
                                 input logic [31:0] pc, input logic mr, input logic ir,
                                 input logic ext);
        logic [31:0] ms, mi;
        rst = r; csr_bus.csr_addr_i = addr; csr_bus.csr_op_i = op; csr_bus.csr_wdata_i = wd;
        trap = tr; trap_cause = cause; trap_pc = pc; mret = mr; instret = ir; irq_ext = ext;
        model_step(r, addr, op, wd, tr, cause, pc, mr, ir, ext);
        @(posedge clk);
        #1;
        ms = m_csr['h300];
        mi = m_csr['h304];
        checkOutput("rdata", csr_bus.csr_rdata_o, exp_rdata);
        checkOutput("illegal", {31'd0, csr_bus.csr_illegal_o}, {31'd0, exp_ill});
        checkOutput("mtvec_o", mtvec_o, m_csr['h305]);
        checkOutput("mepc_o", mepc_o, m_csr['h341]);
        checkOutput("irq_o", {31'd0, irq_o}, {31'd0, ms[3] & mi[11] & ext});
    endtask

    task automatic csrOp(input logic [11:0] addr, input logic [1:0] op, input logic [31:0] wd);
        applyStimulus(1'b0, addr, op, wd, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic [11:0] addr;
        logic [1:0]  op;
        logic [31:0] wdata;
        logic        trap;
        logic [31:0] cause;
        logic [31:0] pc;
        logic        mret;
        logic        irq_ext;
        logic [31:0] exp_rdata;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [11:0] addr, logic [1:0] op, logic [31:0] wd,
                                logic tr, logic [31:0] cause, logic [31:0] pc, logic mr,
                                logic ext, logic [31:0] er, logic ei);
        vec_t v;
        v.addr = addr; v.op = op; v.wdata = wd; v.trap = tr; v.cause = cause; v.pc = pc;
        v.mret = mr; v.irq_ext = ext; v.exp_rdata = er; v.exp_ill = ei;
        return v;
    endfunction

    logic [11:0] addr_pool [20] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h306, 12'h341,
                                    12'h342, 12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82,
                                    12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h7C0, 12'hFFF,
                                    12'h100, 12'h343};

    initial begin
        rst = 1'b1; trap = 0; mret = 0; instret = 0; irq_ext = 0;
        trap_cause = 0; trap_pc = 0;
        csr_bus.csr_addr_i = 0; csr_bus.csr_op_i = 0; csr_bus.csr_wdata_i = 0;
        model_reset();

        applyStimulus(1'b1, 12'h305, 2'b01, 32'hFFFF_FFFF, 1'b1, 32'h7, 32'h40, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 12'h0, 2'b00, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset mtvec_o", mtvec_o, 32'h0000_1000);
        checkOutput("reset mepc_o", mepc_o, 32'h0);

        vecs.push_back(mk(12'h300, 2'b10, 32'h0, 0, 0, 0, 0, 0, 32'h0000_1800, 0));
        vecs.push_back(mk(12'hF14, 2'b10, 32'h0, 0, 0, 0, 0, 0, 32'h5, 0));
        vecs.push_back(mk(12'h305, 2'b01, 32'h8000_0103, 0, 0, 0, 0, 0, 32'h0000_1000, 0));
        vecs.push_back(mk(12'h305, 2'b10, 32'h0000_0010, 0, 0, 0, 0, 0, 32'h8000_0100, 0));
        vecs.push_back(mk(12'h305, 2'b10, 32'h0, 0, 0, 0, 0, 0, 32'h8000_0110, 0));
        vecs.push_back(mk(12'h300, 2'b10, 32'h8, 0, 0, 0, 0, 0, 32'h0000_1800, 0));
        vecs.push_back(mk(12'h305, 2'b01, 32'hDEAD_BEEF, 1, 32'hB, 32'h1236, 0, 0, 32'h0, 0));
        vecs.push_back(mk(12'h341, 2'b10, 32'h0, 0, 0, 0, 0, 0, 32'h0000_1234, 0));
        vecs.push_back(mk(12'h342, 2'b10, 32'h0, 0, 0, 0, 0, 0, 32'h0000_000B, 0));
        vecs.push_back(mk(12'h300, 2'b10, 32'h0, 0, 0, 0, 0, 0, 32'h0000_1880, 0));
        vecs.push_back(mk(12'h305, 2'b10, 32'h0, 0, 0, 0, 0, 0, 32'h8000_0110, 0));
        vecs.push_back(mk(12'h000, 2'b00, 32'h0, 0, 0, 0, 1, 0, 32'h0, 0));
        vecs.push_back(mk(12'h300, 2'b10, 32'h0, 0, 0, 0, 0, 0, 32'h0000_1888, 0));
        vecs.push_back(mk(12'hF11, 2'b01, 32'h1, 0, 0, 0, 0, 0, 32'h0, 1));
        vecs.push_back(mk(12'h7C0, 2'b10, 32'h0, 0, 0, 0, 0, 0, 32'h0, 1));
        vecs.push_back(mk(12'hF11, 2'b10, 32'h0, 0, 0, 0, 0, 0, 32'h0000_0ABC, 0));
        vecs.push_back(mk(12'h301, 2'b01, 32'h0, 0, 0, 0, 0, 0, 32'h4000_0100, 0));
        vecs.push_back(mk(12'h301, 2'b10, 32'h0, 0, 0, 0, 0, 0, 32'h4000_0100, 0));
        vecs.push_back(mk(12'h304, 2'b01, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 32'h0, 0));
        vecs.push_back(mk(12'h344, 2'b01, 32'h0, 0, 0, 0, 0, 1, 32'h0000_0800, 0));
        vecs.push_back(mk(12'h304, 2'b10, 32'h0, 0, 0, 0, 0, 1, 32'h0000_0800, 0));
        vecs.push_back(mk(12'h341, 2'b01, 32'h5557, 0, 0, 0, 0, 0, 32'h0000_1234, 0));
        vecs.push_back(mk(12'h341, 2'b10, 32'h0, 0, 0, 0, 0, 0, 32'h0000_5554, 0));
        vecs.push_back(mk(12'h300, 2'b11, 32'h8, 0, 0, 0, 0, 0, 32'h0000_1888, 0));
        vecs.push_back(mk(12'h300, 2'b01, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 32'h0000_1880, 0));
        vecs.push_back(mk(12'h300, 2'b10, 32'h0, 0, 0, 0, 0, 0, 32'h0000_1888, 0));
        vecs.push_back(mk(12'h306, 2'b01, 32'h5, 0, 0, 0, 0, 0, 32'h0, 0));
        vecs.push_back(mk(12'h306, 2'b10, 32'h0, 0, 0, 0, 0, 0, 32'h5, 0));
        vecs.push_back(mk(12'hF13, 2'b10, 32'h0, 0, 0, 0, 0, 0, 32'h0, 0));
        vecs.push_back(mk(12'h000, 2'b00, 32'h0, 0, 0, 0, 0, 0, 32'h0, 0));

        foreach (vecs[i]) begin
            applyStimulus(1'b0, vecs[i].addr, vecs[i].op, vecs[i].wdata, vecs[i].trap,
                          vecs[i].cause, vecs[i].pc, vecs[i].mret, 1'b0, vecs[i].irq_ext);
            checkOutput($sformatf("vec%0d rdata", i), csr_bus.csr_rdata_o, vecs[i].exp_rdata);
            checkOutput($sformatf("vec%0d illegal", i), {31'd0, csr_bus.csr_illegal_o},
                        {31'd0, vecs[i].exp_ill});
        end

        // Both counters forced to all-ones wrap to zero on the next increment.
        csrOp(12'hB00, 2'b01, 32'hFFFF_FFFF);
        csrOp(12'hB80, 2'b01, 32'hFFFF_FFFF);
        csrOp(12'h000, 2'b00, 32'h0);
        csrOp(12'hB00, 2'b10, 32'h0);
        checkOutput("mcycle wrap", csr_bus.csr_rdata_o, 32'h0);
        csrOp(12'hB80, 2'b10, 32'h0);
        checkOutput("mcycleh wrap", csr_bus.csr_rdata_o, 32'h0);
        csrOp(12'hB02, 2'b01, 32'hFFFF_FFFF);
        csrOp(12'hB82, 2'b01, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 12'h0, 2'b00, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        csrOp(12'hB02, 2'b10, 32'h0);
        checkOutput("minstret wrap", csr_bus.csr_rdata_o, 32'h0);
        checkOutput("minstret illegal", {31'd0, csr_bus.csr_illegal_o}, 32'h0);

        // Reset while a trap and a CSR write are both requested.
        csrOp(12'h305, 2'b01, 32'h0000_2000);
        applyStimulus(1'b1, 12'h305, 2'b01, 32'hFFFF_0000, 1'b1, 32'h3, 32'h88, 1'b0, 1'b1, 1'b1);
        checkOutput("rst-mid mtvec_o", mtvec_o, 32'h0000_1000);
        checkOutput("rst-mid mepc_o", mepc_o, 32'h0);
        checkOutput("rst-mid rdata", csr_bus.csr_rdata_o, 32'h0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] wd;
            wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            applyStimulus($urandom_range(0, 99) == 0, addr_pool[$urandom_range(0, 19)],
                          2'($urandom_range(0, 3)), wd, $urandom_range(0, 15) == 0,
                          $urandom, $urandom, $urandom_range(0, 15) == 0,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
